uart_txrx: RTL and testbench
============================

// Module: uart_txrx
// PURPOSE
//   Full-duplex UART: parallel-in/serial-out transmitter plus oversampling receiver sharing one clock.
//   Frame: start(0), data LSB-first, optional parity, stop(1). Sits between a byte-wide host interface and the pins.
//   Verified in loopback (serial_in tied to serial_out).
// PARAMETERS
//   INPUT_DATA_WIDTH  8  data bits per frame
//   PARITY_ENABLED    1  1 = parity bit present, 0 = no parity bit and no PARITY_BIT state
//   PARITY_TYPE       0  0 = even (bit = ^data), 1 = odd (bit = ~^data)
//   CLOCKS_PER_BIT    8  clk cycles per serial bit
// PORTS
//   clk            in   1  single clock
//   reset          in   1  asynchronous, active-high
//   enable         in   1  one-cycle request to transmit i_data; ignored while o_busy=1
//   i_data         in   W  byte to send; held stable by host while request pending/busy
//   o_busy         out  1  Tx frame in progress
//   serial_out     out  1  Tx line, idles high
//   serial_in      in   1  Rx line, asynchronous to clk
//   received_data  out  W  last correctly received byte
//   data_is_valid  out  1  one-cycle pulse: received_data updated
//   rx_error       out  1  one-cycle pulse: parity mismatch or stop bit = 0
// BEHAVIOUR
//   Reset: serial_out=1, o_busy=0, data_is_valid=0, rx_error=0, received_data=0, Rx state=IDLE,
//     Tx shift register all ones, baud counter=0. Reset mid-frame aborts both directions immediately.
//   Baud: free-running counter 0..CLOCKS_PER_BIT-1; baud_clk pulses one clk when counter wraps.
//   Tx: enable && !o_busy latches i_data; o_busy=1 next cycle. Next baud_clk loads
//     shift_reg (W+PARITY_ENABLED+2 bits) with frame, serial_out=0 (start). Each later baud_clk shifts one bit.
//     After the stop bit has been driven for a full bit period, o_busy=0, shift_reg back to all ones, serial_out=1.
//     enable while busy is dropped (no queue). Back-to-back: enable allowed the cycle o_busy falls.
//   Rx: 3-FF synchronizer on serial_in. States (4-bit): IDLE=0, START_BIT=1, DATA_BIT_0..7=2..9,
//     PARITY_BIT=10, STOP_BIT=11. IDLE->START_BIT on synchronized 0. At half bit period re-sample:
//     1 -> IDLE (glitch), 0 -> DATA_BIT_0. Then sample every CLOCKS_PER_BIT clks mid-bit, shifting LSB-first.
//     After last data bit -> PARITY_BIT (or STOP_BIT if PARITY_ENABLED=0) -> STOP_BIT -> IDLE.
//     At stop sample: stop=1 and parity ok -> received_data<=shift, data_is_valid pulse;
//     else rx_error pulse, received_data unchanged. Outputs registered; both pulses never coincide.
//   Loopback latency enable->data_is_valid: <= (W+3+1)*CLOCKS_PER_BIT + 3 sync + 2 clks.
// CONFIGURATION
//   UART_DEBUG_PORTS_EN: defined -> extra outputs state[3:0] (Rx state), baud_clk[0], shift_reg[W+PARITY_ENABLED+1:0]
//     (Tx PISO) exported for formal/debug. Undefined -> ports absent, functional behaviour identical.
// STRUCTURE
//   uart_pkg: Rx state localparams, NUMBER_OF_BITS = W+3, NUMBER_OF_RX_SYNCHRONIZERS = 3, parity helper function.
//   One sub-module: uart_sync3 (3-FF synchronizer, reset value 1). Tx, baud gen, Rx FSM inline.
// TESTING
//   Reset then idle 50 clks -> serial_out=1, o_busy=0, data_is_valid=0, shift_reg all ones.
//   Loopback, enable with i_data=8'hA5 -> start bit 0 first, bits 1,0,1,0,0,1,0,1, parity 0, stop 1;
//     data_is_valid pulses once with received_data=8'hA5, rx_error=0.
//   enable pulsed again while o_busy=1 (i_data=8'h3C) -> ignored, only 8'hA5 received.
//   Drive serial_in directly with 8'h01 frame and parity bit flipped -> rx_error pulse, received_data unchanged.
//   Drive 0 on serial_in for 2 clks only -> Rx returns IDLE, no pulse.
//   Assert reset mid-frame -> outputs at reset values next cycle; subsequent 8'hFF frame received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_txrx UART: Rx state encoding, frame sizing,
// synchronizer depth and the parity helper used by both directions.
package uart_pkg;

  localparam int UART_DATA_WIDTH            = 8;
  localparam int NUMBER_OF_BITS             = UART_DATA_WIDTH + 3;
  localparam int NUMBER_OF_RX_SYNCHRONIZERS = 3;

  // Data states are consecutive so the receiver can step through them arithmetically.
  typedef enum logic [3:0] {
    RX_IDLE       = 4'd0,
    RX_START_BIT  = 4'd1,
    RX_DATA_BIT_0 = 4'd2,
    RX_DATA_BIT_1 = 4'd3,
    RX_DATA_BIT_2 = 4'd4,
    RX_DATA_BIT_3 = 4'd5,
    RX_DATA_BIT_4 = 4'd6,
    RX_DATA_BIT_5 = 4'd7,
    RX_DATA_BIT_6 = 4'd8,
    RX_DATA_BIT_7 = 4'd9,
    RX_PARITY_BIT = 4'd10,
    RX_STOP_BIT   = 4'd11
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_WAIT = 2'd1,
    TX_SEND = 2'd2
  } tx_state_e;

  // Zero-extension of the data does not change the XOR reduction.
  function automatic logic parity_bit(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Host-side byte interface of uart_txrx; master = host, slave = UART.
// enable is a one-cycle request taken only while o_busy is low (no back-pressure beyond that);
// data_is_valid and rx_error are one-cycle strobes that the host must catch when they occur.
interface uart_if #(parameter int W = 8);
  logic         enable;
  logic [W-1:0] i_data;
  logic         o_busy;
  logic [W-1:0] received_data;
  logic         data_is_valid;
  logic         rx_error;

  modport master (
    output enable, i_data,
    input  o_busy, received_data, data_is_valid, rx_error
  );

  modport slave (
    input  enable, i_data,
    output o_busy, received_data, data_is_valid, rx_error
  );
endinterface

// File: rtl/uart_sync3.sv
// Multi-flop synchronizer for the asynchronous Rx line; resets to the idle (high) level.
module uart_sync3
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int N = NUMBER_OF_RX_SYNCHRONIZERS;

  logic [N-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[N-2:0], d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '1;
    else       sync_q <= sync_d;
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: shared baud counter, PISO transmitter and mid-bit sampling receiver.
// Define UART_DEBUG_PORTS_EN to export the Rx state, baud tick and Tx shift register.
module uart_txrx
  import uart_pkg::*;
#(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int PARITY_TYPE      = 0,
  parameter int CLOCKS_PER_BIT   = 8
) (
  input  logic   clk,
  input  logic   reset,
  uart_if.slave  host,
  output logic   serial_out,
  input  logic   serial_in
`ifdef UART_DEBUG_PORTS_EN
  ,
  output logic [3:0] state,
  output logic       baud_clk,
  output logic [INPUT_DATA_WIDTH+PARITY_ENABLED+1:0] shift_reg
`endif
);

  localparam int W          = INPUT_DATA_WIDTH;
  localparam int FRAME_BITS = W + PARITY_ENABLED + 2;
  localparam int BW         = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam int TBW        = $clog2(FRAME_BITS);
  localparam logic [BW-1:0]  BAUD_MAX  = BW'(CLOCKS_PER_BIT - 1);
  localparam logic [BW-1:0]  HALF_BIT  = BW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [TBW-1:0] TX_LAST   = TBW'(FRAME_BITS - 1);
  localparam logic [3:0]     LAST_DATA = 4'(RX_DATA_BIT_0 + W - 1);
  localparam logic           ODD       = (PARITY_TYPE != 0);

  // ---------------- baud generator ----------------
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic          baud_tick;

  always_comb begin
    baud_tick  = (baud_cnt_q == BAUD_MAX);
    baud_cnt_d = baud_tick ? '0 : baud_cnt_q + 1'b1;
  end

  // ---------------- transmitter ----------------
  tx_state_e             tx_state_q, tx_state_d;
  logic [W-1:0]          tx_data_q, tx_data_d;
  logic [FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [TBW-1:0]        tx_bit_q, tx_bit_d;
  logic [FRAME_BITS-1:0] tx_frame;

  // Frame bit 0 leaves the line first: start, data LSB-first, optional parity, stop.
  always_comb begin
    tx_frame      = '1;
    tx_frame[0]   = 1'b0;
    tx_frame[W:1] = tx_data_q;
    if (PARITY_ENABLED != 0) tx_frame[W+1] = parity_bit(32'(tx_data_q), ODD);
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_shift_d = tx_shift_q;
    tx_bit_d   = tx_bit_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (host.enable) begin
          tx_data_d  = host.i_data;
          tx_state_d = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (baud_tick) begin
          tx_shift_d = tx_frame;
          tx_bit_d   = '0;
          tx_state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        if (baud_tick) begin
          if (tx_bit_q == TX_LAST) begin
            tx_shift_d = '1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[FRAME_BITS-1:1]};
            tx_bit_d   = tx_bit_q + 1'b1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign serial_out  = tx_shift_q[0];
  assign host.o_busy = (tx_state_q != TX_IDLE);

  // ---------------- receiver ----------------
  logic          rx_s;
  rx_state_e     rx_state_q, rx_state_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [W-1:0]  rx_shift_q, rx_shift_d;
  logic          rx_par_q, rx_par_d;
  logic [W-1:0]  rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_err_q, rx_err_d;
  logic          rx_sample;
  logic          rx_par_ok;

  uart_sync3 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (serial_in),
    .q     (rx_s)
  );

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_sample  = (rx_cnt_q == BAUD_MAX);
    rx_par_ok  = (PARITY_ENABLED == 0) || (rx_par_q == parity_bit(32'(rx_shift_q), ODD));
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START_BIT;
          rx_cnt_d   = '0;
        end
      end
      RX_START_BIT: begin
        // A start bit that is gone by mid-bit was a glitch.
        if (rx_cnt_q == HALF_BIT) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA_BIT_0;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY_BIT: begin
        if (rx_sample) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_s;
          rx_state_d = RX_STOP_BIT;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP_BIT: begin
        if (rx_sample) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s && rx_par_ok) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: begin
        if (rx_state_q >= RX_DATA_BIT_0 && rx_state_q <= LAST_DATA) begin
          if (rx_sample) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s, rx_shift_q[W-1:1]};
            if (rx_state_q == LAST_DATA)
              rx_state_d = (PARITY_ENABLED != 0) ? RX_PARITY_BIT : RX_STOP_BIT;
            else
              rx_state_d = rx_state_e'(rx_state_q + 4'd1);
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
    endcase
  end

  assign host.received_data = rx_data_q;
  assign host.data_is_valid = rx_valid_q;
  assign host.rx_error      = rx_err_q;

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt_q <= '0;
      tx_state_q <= TX_IDLE;
      tx_data_q  <= '0;
      tx_shift_q <= '1;
      tx_bit_q   <= '0;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
      tx_shift_q <= tx_shift_d;
      tx_bit_q   <= tx_bit_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

`ifdef UART_DEBUG_PORTS_EN
  assign state     = rx_state_q;
  assign baud_clk  = baud_tick;
  assign shift_reg = tx_shift_q;
`endif

endmodule

// File: tb/tb_uart_txrx.sv
// Bench for uart_txrx: cycle-timeline model of the Tx line and busy flag, plus an expected
// queue of received bytes / errors with latency deadlines, checked every cycle.
module tb_uart_txrx;

  localparam int W     = 8;
  localparam int PE    = 1;
  localparam int PT    = 0;
  localparam int CPB   = 8;
  localparam int FRAME = W + PE + 2;
  localparam int LAT   = (W + 4) * CPB + 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  logic serial_out, serial_in;
  logic loopback = 1'b1;
  logic drv_line = 1'b1;
  assign serial_in = loopback ? serial_out : drv_line;

  uart_if #(.W(W)) host_if ();

`ifdef UART_DEBUG_PORTS_EN
  logic [3:0]       dbg_state;
  logic             dbg_baud;
  logic [FRAME-1:0] dbg_shift;
`endif

  uart_txrx #(
    .INPUT_DATA_WIDTH (W),
    .PARITY_ENABLED   (PE),
    .PARITY_TYPE      (PT),
    .CLOCKS_PER_BIT   (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .host       (host_if.slave),
    .serial_out (serial_out),
    .serial_in  (serial_in)
`ifdef UART_DEBUG_PORTS_EN
    ,
    .state      (dbg_state),
    .baud_clk   (dbg_baud),
    .shift_reg  (dbg_shift)
`endif
  );

  // ---------------- model ----------------
  int tests = 0;
  int fails = 0;

  bit               tx_valid;
  int               tx_t, tx_c;
  logic [FRAME-1:0] tx_frame;

  logic [W-1:0] exp_q[$];
  bit           exp_err_q[$];
  int           exp_dl_q[$];
  logic [W-1:0] last_good;
  bit           chk_en;
  int           pulses;
  logic         dv_prev;

  // Bit k of the result is the k-th bit on the line (start first); even parity, optionally flipped.
  function automatic logic [FRAME-1:0] frame_of(input logic [W-1:0] d, input bit flip);
    return {1'b1, (^d) ^ flip, d, 1'b0};
  endfunction

  function automatic bit model_busy(input int n);
    return tx_valid && (n >= tx_t + 1) && (n <= tx_c + FRAME * CPB);
  endfunction

  function automatic logic model_line(input int n);
    if (tx_valid && (n >= tx_c + 1) && (n < tx_c + 1 + FRAME * CPB))
      return tx_frame[(n - tx_c - 1) / CPB];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] d, input bit is_err, input int dl);
    exp_q.push_back(d);
    exp_err_q.push_back(is_err);
    exp_dl_q.push_back(dl);
  endtask

  task automatic clear_model();
    tx_valid = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    exp_dl_q.delete();
    last_good = '0;
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset && chk_en) begin
      check("o_busy", host_if.o_busy, model_busy(cyc));
      check("serial_out", serial_out, model_line(cyc));
      check("pulse_excl", host_if.data_is_valid & host_if.rx_error, 0);
      check("dv_width", host_if.data_is_valid & dv_prev, 0);
`ifdef UART_DEBUG_PORTS_EN
      check("baud_clk", dbg_baud, (cyc % CPB) == CPB - 1);
`endif
      if (host_if.data_is_valid || host_if.rx_error) begin
        pulses++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: dv=%b err=%b data=%0h, nothing expected (cycle %0d)",
                   host_if.data_is_valid, host_if.rx_error, host_if.received_data, cyc);
        end else begin
          check("rx_kind", host_if.rx_error, exp_err_q[0]);
          if (!exp_err_q[0]) begin
            check("rx_data", host_if.received_data, exp_q[0]);
            last_good = exp_q[0];
          end else begin
            check("rx_hold_err", host_if.received_data, last_good);
          end
          void'(exp_q.pop_front());
          void'(exp_err_q.pop_front());
          void'(exp_dl_q.pop_front());
        end
      end else begin
        check("rx_hold", host_if.received_data, last_good);
      end
      if (exp_q.size() != 0 && cyc > exp_dl_q[0]) begin
        tests++;
        fails++;
        $display("FAIL rx_timeout: no pulse for %0h by cycle %0d (now %0d)", exp_q[0], exp_dl_q[0], cyc);
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
        void'(exp_dl_q.pop_front());
      end
      dv_prev = host_if.data_is_valid;
    end else begin
      dv_prev = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic host_send(input logic [W-1:0] d, input bit wait_free, output bit acc);
    int b;
    @(posedge clk); #1;
    b = 0;
    while (wait_free && model_busy(cyc) && b < 2000) begin
      @(posedge clk); #1;
      b++;
    end
    host_if.i_data = d;
    host_if.enable = 1'b1;
    acc = !model_busy(cyc);
    if (acc) begin
      tx_t = cyc;
      tx_c = cyc + 1;
      while (tx_c % CPB != CPB - 1) tx_c++;
      tx_frame = frame_of(d, 1'b0);
      tx_valid = 1'b1;
      if (loopback) push_exp(d, 1'b0, cyc + LAT);
    end
    @(posedge clk); #1;
    host_if.enable = 1'b0;
  endtask

  task automatic drive_frame(input logic [FRAME-1:0] f, input bit is_err, input logic [W-1:0] d);
    @(posedge clk); #1;
    push_exp(d, is_err, cyc + FRAME * CPB + CPB);
    for (int k = 0; k < FRAME; k++) begin
      drv_line = f[k];
      repeat (CPB) @(posedge clk);
      #1;
    end
    drv_line = 1'b1;
  endtask

  task automatic wait_rx(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      @(negedge clk);
      b++;
    end
    check("rx_drain", exp_q.size(), 0);
  endtask

  task automatic wait_cyc(input int target);
    int b;
    b = 0;
    while (cyc < target && b < 1000) begin
      @(negedge clk);
      b++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_serial_out"}, serial_out, 1);
    check({tag, "_busy"}, host_if.o_busy, 0);
    check({tag, "_dv"}, host_if.data_is_valid, 0);
    check({tag, "_err"}, host_if.rx_error, 0);
    check({tag, "_rdata"}, host_if.received_data, 0);
`ifdef UART_DEBUG_PORTS_EN
    check({tag, "_state"}, dbg_state, 0);
    check({tag, "_shift"}, dbg_shift, {FRAME{1'b1}});
`endif
  endtask

  // ---------------- stimulus ----------------
  logic [FRAME-1:0] cap;
  bit acc_a, acc_b;
  int p0;

  initial begin
    host_if.enable = 1'b0;
    host_if.i_data = '0;
    chk_en  = 1'b0;
    dv_prev = 1'b0;
    pulses  = 0;
    clear_model();

    reset = 1'b1;
    @(negedge clk);
    check_reset_values("rst_in");
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    repeat (50) @(posedge clk);
    @(negedge clk);
    check_reset_values("idle50");

    check("model_frame_a5", frame_of(8'hA5, 1'b0), 11'h54A);
    check("model_frame_01_badpar", frame_of(8'h01, 1'b1), 11'h402);

    // A5 in loopback; a second request while busy must be dropped.
    p0 = pulses;
    host_send(8'hA5, 1'b0, acc_a);
    check("a5_accepted", acc_a, 1);
    fork
      begin
        for (int k = 0; k < FRAME; k++) begin
          wait_cyc(tx_c + 1 + k * CPB + CPB / 2);
          cap[k] = serial_out;
        end
      end
      begin
        repeat (20) @(posedge clk);
        host_send(8'h3C, 1'b0, acc_b);
        check("3c_dropped", acc_b, 0);
      end
    join
    check("a5_line_bits", cap, 11'h54A);
    wait_rx(LAT + 20);
    check("a5_pulses", pulses - p0, 1);
    check("a5_rdata", host_if.received_data, 8'hA5);

    // Back-to-back: second request on the very cycle o_busy falls.
    p0 = pulses;
    host_send(8'h3C, 1'b0, acc_a);
    host_send(8'hC3, 1'b1, acc_b);
    check("b2b_accepted", acc_b, 1);
    wait_rx(2 * LAT);
    check("b2b_pulses", pulses - p0, 2);
    check("b2b_rdata", host_if.received_data, 8'hC3);

    // Directly driven frames: good byte, then bad parity.
    repeat (4) @(posedge clk);
    loopback = 1'b0;
    p0 = pulses;
    drive_frame(frame_of(8'h96, 1'b0), 1'b0, 8'h96);
    wait_rx(4 * CPB);
    drive_frame(frame_of(8'h01, 1'b1), 1'b1, 8'h01);
    wait_rx(4 * CPB);
    check("direct_pulses", pulses - p0, 2);
    check("perr_rdata_kept", host_if.received_data, 8'h96);

    // Two-clock low glitch must not start a frame.
    repeat (10) @(posedge clk);
    p0 = pulses;
    #1 drv_line = 1'b0;
    repeat (2) @(posedge clk);
    #1 drv_line = 1'b1;
    repeat (3 * CPB) @(posedge clk);
    check("glitch_no_pulse", pulses - p0, 0);
`ifdef UART_DEBUG_PORTS_EN
    @(negedge clk);
    check("glitch_state_idle", dbg_state, 0);
`endif

    // Reset in the middle of a loopback frame, then a clean FF frame.
    loopback = 1'b1;
    host_send(8'h5A, 1'b0, acc_a);
    repeat (40) @(posedge clk);
    #1;
    chk_en = 1'b0;
    reset  = 1'b1;
    clear_model();
    @(negedge clk);
    check_reset_values("mid_rst");
    @(posedge clk); #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    p0 = pulses;
    host_send(8'hFF, 1'b0, acc_a);
    wait_rx(LAT + 20);
    check("ff_pulses", pulses - p0, 1);
    check("ff_rdata", host_if.received_data, 8'hFF);
    repeat (20) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++;
    fails++;
    $display("FAIL watchdog: bench did not complete (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
